mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side end of the multicycle CPU's mem_read/mem_write/mem_resp handshake.
- Single-port word-addressed storage with configurable, fixed response latency and byte-enable writes.
- Sits opposite the CPU control/datapath as the synthesizable memory used in simulation and FPGA bring-up.
- Returns exactly one mem_resp pulse per accepted request, with error signalling for illegal requests.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, at least 4
LATENCY, 3, cycles from request accept to mem_resp; range 1 to 15
ADDR_BASE, 32'h0000_0000, byte address of word 0; word-aligned

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
mem_read  in  1  read request, held by initiator until mem_resp
mem_write  in  1  write request, held by initiator until mem_resp
mem_address  in  32  byte address; bits [1:0] ignored
mem_wdata  in  32  write data
mem_byte_enable  in  4  bit i enables write of byte lane i (mem_wdata[8i+7:8i])
mem_resp  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid in the mem_resp cycle, held until next read response
mem_err  out  1  one-cycle pulse coincident with mem_resp for an illegal request

Behaviour:
- Reset (sync, active-high): mem_resp=0, mem_rdata=0, mem_err=0, state=IDLE, counter=0. Storage contents are not cleared.
- Reset mid-operation aborts the transaction: no write commit and no mem_resp.
- States:
  - IDLE: wait for a request.
  - WAIT: count down.
  - RESP: drive mem_resp for one cycle.
- IDLE:
  - If mem_read or mem_write is 1, accept the request at the clock edge and go to WAIT, or go directly to RESP if LATENCY=1.
  - On accept, capture address, wdata, byte_enable, the op (read/write) and the legality check.
  - Counter loads LATENCY-1.
- WAIT:
  - Decrement the counter each cycle; at 1, go to RESP.
  - If mem_read and mem_write are both 0 in any WAIT cycle, abort to IDLE with no response and no write.
- RESP:
  - mem_resp=1 for exactly this cycle; always go to IDLE next.
  - A request seen in the RESP cycle is not accepted. The initiator deasserts after mem_resp, and a request can be accepted no earlier than the cycle after RESP.
- Timing: with a request first high in cycle t, mem_resp is high in cycle t+LATENCY.
- Read: mem_rdata is set to the full 32-bit word at the captured index in the RESP cycle. byte_enable is ignored for reads.
- Write:
  - Commit at the RESP-cycle clock edge, only lanes whose mem_byte_enable bit is 1; other lanes are unchanged.
  - mem_rdata is unchanged by writes.
  - byte_enable=0000 is a legal no-op write.
- Index = (mem_address - ADDR_BASE) >> 2.
- Illegal requests complete normally but with mem_err=1 and the storage untouched:
  - Out of range: address < ADDR_BASE or index >= DEPTH_WORDS. A read returns mem_rdata=0.
  - mem_read and mem_write both 1 at accept. mem_rdata is unchanged.
- Captured values are used for the whole transaction. Input changes after accept are ignored, apart from the abort rule.
- Storage is an inferred single-port synchronous RAM; no read-during-write forwarding is needed because access is serialized.

Decomposition:
- Package mem_responder_types:
  - state enum (IDLE, WAIT, RESP)
  - word_t (32-bit)
  - mask_t (4-bit)
  - function merging old word, new data and mask
- Sub-module mem_responder_array: DEPTH_WORDS x 32 storage with per-byte write enables and a registered read port.
- FSM, counter, capture registers and legality check stay in mem_responder.

Test Plan:
- Write then read, LATENCY=3: sw 0xDEADBEEF, be=1111 to addr 0x10, request in cycle 5 -> mem_resp in cycle 8. Read addr 0x10 -> mem_rdata=0xDEADBEEF, mem_err=0.
- Byte lanes: word 0x11223344 at 0x20, write be=0001 data 0x000000AA -> read 0x112233AA. Then be=0011 data 0x0000BEEF -> read 0x1122BEEF.
- Latency sweep, LATENCY=1 and 15: mem_resp exactly 1 and 15 cycles after request rise. Pulse width is 1 cycle; no second pulse while the request is held through RESP.
- Errors: read index DEPTH_WORDS -> mem_resp with mem_err=1, mem_rdata=0. mem_read=mem_write=1 -> mem_err=1, storage unchanged on readback.
- Abort: drop mem_write in WAIT (LATENCY=4) -> no mem_resp, target word unchanged. A new read accepted the next cycle completes normally.
- Reset mid-transaction: rst in WAIT of a write -> mem_resp=0, mem_err=0, mem_rdata=0, no commit. Storage from earlier writes still reads back after reset.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and byte-lane merge helper for mem_responder
package mem_responder_types;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  mask_t;

   // Replace only the byte lanes whose mask bit is set.
   function automatic word_t word_merge(input word_t old_word, input word_t new_word,
                                        input mask_t mask);
      word_t merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - single-port word storage with byte-lane writes and registered read
module mem_responder_array
   import mem_responder_types::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_WIDTH  = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   word_t mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= word_merge(mem[addr], wdata, be);
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder for the mem_read/mem_write/mem_resp handshake
module mem_responder
   import mem_responder_types::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 3,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_byte_enable,
   output logic        mem_resp,
   output logic [31:0] mem_rdata,
   output logic        mem_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t         state, state_next;
   logic [3:0]     count;
   logic [AW-1:0]  index_q;
   word_t          wdata_q;
   mask_t          be_q;
   logic           rd_q, wr_q, oor_q;
   word_t          rdata_q, ram_rdata;

   logic           borrow;
   logic [31:0]    offset;
   logic [AW-1:0]  index_in;
   logic           oor_in;
   logic           accept, ram_we, rdata_load;
   logic [AW-1:0]  ram_addr;

   // Borrow out of the subtraction flags addresses below the base.
   assign {borrow, offset} = {1'b0, mem_address} - {1'b0, ADDR_BASE};
   assign index_in = offset[AW+1:2];
   assign oor_in   = borrow || (offset >= 32'(DEPTH_WORDS * 4));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (mem_read || mem_write) state_next = (LATENCY == 1) ? RESP : WAIT;
         WAIT: begin
            if (!mem_read && !mem_write) state_next = IDLE;
            else if (count == 4'd1)      state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // In IDLE the RAM looks at the live index so a LATENCY=1 read is ready in RESP.
   always_comb begin
      accept     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = index_q;
      rdata_load = 1'b0;
      mem_resp   = 1'b0;
      mem_err    = 1'b0;
      unique case (state)
         IDLE: begin
            accept   = mem_read | mem_write;
            ram_addr = index_in;
         end
         WAIT: ;
         RESP: begin
            mem_resp   = 1'b1;
            mem_err    = oor_q | (rd_q & wr_q);
            ram_we     = wr_q & ~rd_q & ~oor_q;
            rdata_load = rd_q & ~wr_q;
         end
         default: ;
      endcase
   end

   assign mem_rdata = rdata_load ? (oor_q ? '0 : ram_rdata) : rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= 4'd0;
         index_q <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         oor_q   <= 1'b0;
      end else if (accept) begin
         count   <= 4'(LATENCY - 1);
         index_q <= index_in;
         wdata_q <= mem_wdata;
         be_q    <= mem_byte_enable;
         rd_q    <= mem_read;
         wr_q    <= mem_write;
         oor_q   <= oor_in;
      end else if (state == WAIT) begin
         count <= count - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)             rdata_q <= '0;
      else if (rdata_load) rdata_q <= mem_rdata;
   end

   mem_responder_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_WIDTH  (AW)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .be    (be_q),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench for mem_responder at latencies 3, 1, 15 and 4
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd    [4];
   logic        wr    [4];
   logic [31:0] addr  [4];
   logic [31:0] wdata [4];
   logic [3:0]  be    [4];
   logic        resp  [4];
   logic [31:0] rdata [4];
   logic        err   [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Instance 0: LATENCY 3, 1: LATENCY 1, 2: LATENCY 15, 3: LATENCY 4 with base 0x100.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      mem_responder #(
         .DEPTH_WORDS (64),
         .LATENCY     (g == 0 ? 3 : g == 1 ? 1 : g == 2 ? 15 : 4),
         .ADDR_BASE   (g == 3 ? 32'h0000_0100 : 32'h0000_0000)
      ) u_dut (
         .clk             (clk),
         .rst             (rst),
         .mem_read        (rd[g]),
         .mem_write       (wr[g]),
         .mem_address     (addr[g]),
         .mem_wdata       (wdata[g]),
         .mem_byte_enable (be[g]),
         .mem_resp        (resp[g]),
         .mem_rdata       (rdata[g]),
         .mem_err         (err[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   task automatic req(input int d, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b, input int exp_lat,
                      input bit exp_err, input bit chk_data, input logic [31:0] exp_data,
                      input string tag);
      int k;
      rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
      k = 0;
      @(negedge clk);
      while (!resp[d] && k < 20) begin
         k++;
         @(negedge clk);
      end
      check({tag, " latency"}, 32'(k), 32'(exp_lat));
      check({tag, " err"}, 32'(err[d]), 32'(exp_err));
      if (chk_data) check({tag, " rdata"}, rdata[d], exp_data);
      @(posedge clk); #1;
      rd[d] = 1'b0; wr[d] = 1'b0;
      @(negedge clk);
      check({tag, " single pulse"}, 32'(resp[d]), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset resp", 32'(resp[0]), 32'd0);
      check("reset err", 32'(err[0]), 32'd0);
      check("reset rdata", rdata[0], 32'd0);
      check("reset resp L1", 32'(resp[1]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Latency 3: full write / read and byte lanes
      req(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 3, 0, 0, 0, "wr 0x10");
      req(0, 1, 0, 32'h10, 32'h0, 4'b0000, 3, 0, 1, 32'hDEAD_BEEF, "rd 0x10");
      req(0, 0, 1, 32'h20, 32'h1122_3344, 4'b1111, 3, 0, 1, 32'hDEAD_BEEF, "wr 0x20 keeps rdata");
      req(0, 0, 1, 32'h20, 32'h0000_00AA, 4'b0001, 3, 0, 0, 0, "wr be0001");
      req(0, 1, 0, 32'h20, 32'h0, 4'b1111, 3, 0, 1, 32'h1122_33AA, "rd after be0001");
      req(0, 0, 1, 32'h20, 32'h0000_BEEF, 4'b0011, 3, 0, 0, 0, "wr be0011");
      req(0, 1, 0, 32'h20, 32'h0, 4'b0000, 3, 0, 1, 32'h1122_BEEF, "rd after be0011");
      req(0, 0, 1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 3, 0, 0, 0, "wr be0000");
      req(0, 1, 0, 32'h20, 32'h0, 4'b0000, 3, 0, 1, 32'h1122_BEEF, "rd after no-op");

      // Errors: both ops leave rdata and storage alone; out of range reads zero
      req(0, 1, 1, 32'h10, 32'h0, 4'b1111, 3, 1, 1, 32'h1122_BEEF, "rd+wr both");
      req(0, 1, 0, 32'h10, 32'h0, 4'b0000, 3, 0, 1, 32'hDEAD_BEEF, "rd after both");
      req(0, 1, 0, 32'h100, 32'h0, 4'b0000, 3, 1, 1, 32'h0, "rd index depth");
      req(0, 1, 0, 32'h10, 32'h0, 4'b0000, 3, 0, 1, 32'hDEAD_BEEF, "rd 0x10 again");

      // Latency extremes
      req(1, 0, 1, 32'h8, 32'hCAFE_F00D, 4'b1111, 1, 0, 0, 0, "L1 wr");
      req(1, 1, 0, 32'h8, 32'h0, 4'b0000, 1, 0, 1, 32'hCAFE_F00D, "L1 rd");
      req(2, 0, 1, 32'h4, 32'h1234_5678, 4'b1111, 15, 0, 0, 0, "L15 wr");
      req(2, 1, 0, 32'h4, 32'h0, 4'b0000, 15, 0, 1, 32'h1234_5678, "L15 rd");

      // Latency 4 with base 0x100: abort in WAIT, then an immediate read
      req(3, 0, 1, 32'h104, 32'hAAAA_5555, 4'b1111, 4, 0, 0, 0, "L4 wr");
      wr[3] = 1'b1; addr[3] = 32'h104; wdata[3] = 32'hFFFF_FFFF; be[3] = 4'b1111;
      @(posedge clk); @(posedge clk); #1;
      wr[3] = 1'b0;
      @(negedge clk);
      check("abort no resp", 32'(resp[3]), 32'd0);
      @(posedge clk); #1;
      req(3, 1, 0, 32'h104, 32'h0, 4'b0000, 4, 0, 1, 32'hAAAA_5555, "rd after abort");
      req(3, 1, 0, 32'hFC, 32'h0, 4'b0000, 4, 1, 1, 32'h0, "rd below base");

      // Reset while a write is in WAIT
      wr[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h0BAD_F00D; be[0] = 4'b1111;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; wr[0] = 1'b0;
      @(negedge clk);
      check("mid reset resp", 32'(resp[0]), 32'd0);
      check("mid reset err", 32'(err[0]), 32'd0);
      check("mid reset rdata", rdata[0], 32'd0);
      repeat (4) @(negedge clk);
      check("no late resp", 32'(resp[0]), 32'd0);
      @(posedge clk); #1;
      req(0, 1, 0, 32'h10, 32'h0, 4'b0000, 3, 0, 1, 32'hDEAD_BEEF, "rd 0x10 after reset");
      req(0, 1, 0, 32'h20, 32'h0, 4'b0000, 3, 0, 1, 32'h1122_BEEF, "rd 0x20 after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
